// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC -> instruction-memory fetch port.
package fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instruction} entries; clear empties it on the next edge.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign count  = count_q;
    assign rdata  = mem_q[rd_ptr_q];
    assign do_pop = pop && !empty;

    // NOTE: storage is not reset; count_q gates visibility, so stale words are never presented.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/imem_fetch_port.sv
// Fetch port: issues PC-stage addresses to a variable-latency SRAM and buffers returned
// words with their PC for the ID stage; handles flush squashing and SRAM timeout.
module imem_fetch_port
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_LAT    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              flush,
    input  logic              id_stall,
    output logic              sram_req,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic              sram_ack,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              pc_accept,
    output logic              fetch_busy,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [LAT_W-1:0] MAX_LAT_C = LAT_W'(MAX_LAT);

    fetch_state_t      state_q, state_d;
    logic              sram_req_q, sram_req_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic              discard_q, discard_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              fetch_err_q, fetch_err_d;

    logic              accept;
    logic              room;
    logic              room_reissue;
    logic [LAT_W-1:0]  lat_next;
    logic [ADDR_W-1:0] aligned_pc;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_rdata;

    assign fifo_push    = (state_q == WAIT) && sram_ack && !discard_q && !flush;
    assign fifo_pop     = instr_valid && !id_stall;
    assign room         = (fifo_count + CNT_W'(state_q == WAIT)) < DEPTH_C;
    // On an ack the in-flight slot becomes a FIFO entry, or disappears if the word is dropped.
    assign room_reissue = (fifo_count + CNT_W'(fifo_push)) < DEPTH_C;
    assign lat_next     = lat_cnt_q + LAT_W'(1);
    assign aligned_pc   = fetch_pc & ~ADDR_W'(3);

    // NOTE: every next-state signal takes its default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        sram_req_d  = sram_req_q;
        sram_addr_d = sram_addr_q;
        discard_d   = discard_q;
        lat_cnt_d   = lat_cnt_q;
        fetch_err_d = fetch_err_q;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_req && !flush && room) begin
                    accept      = 1'b1;
                    sram_req_d  = 1'b1;
                    sram_addr_d = aligned_pc;
                    lat_cnt_d   = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (sram_ack) begin
                    discard_d = 1'b0;
                    if (fetch_req && !flush && room_reissue) begin
                        accept      = 1'b1;
                        sram_addr_d = aligned_pc;
                        lat_cnt_d   = '0;
                    end else begin
                        sram_req_d = 1'b0;
                        state_d    = IDLE;
                    end
                end else if (lat_next == MAX_LAT_C) begin
                    fetch_err_d = 1'b1;
                    sram_req_d  = 1'b0;
                    discard_d   = 1'b0;
                    lat_cnt_d   = '0;
                    state_d     = IDLE;
                end else begin
                    discard_d = discard_q || flush;
                    lat_cnt_d = lat_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sram_req_q  <= 1'b0;
            sram_addr_q <= '0;
            discard_q   <= 1'b0;
            lat_cnt_q   <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sram_req_q  <= sram_req_d;
            sram_addr_q <= sram_addr_d;
            discard_q   <= discard_d;
            lat_cnt_q   <= lat_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({sram_addr_q, sram_rdata}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

    // Handshake outputs are held low while reset is asserted, whatever the PC stage drives.
    assign pc_accept   = rst_n && accept;
    assign fetch_busy  = rst_n && fetch_req && !accept;
    assign instr_valid = !fifo_empty;
    assign instr       = instr_valid ? fifo_rdata[DATA_W-1:0] : DATA_W'(NOP_INSTR);
    assign instr_pc    = instr_valid ? fifo_rdata[ENT_W-1:DATA_W] : '0;
    assign sram_req    = sram_req_q;
    assign sram_addr   = sram_addr_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based occupancy model.
module tb_imem_fetch_port;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 2;
    localparam int MAX_LAT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_pc;
    logic              flush;
    logic              id_stall;
    logic              sram_req;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ack;
    logic [DATA_W-1:0] sram_rdata;
    logic              pc_accept;
    logic              fetch_busy;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    imem_fetch_port #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .MAX_LAT    (MAX_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .flush       (flush),
        .id_stall    (id_stall),
        .sram_req    (sram_req),
        .sram_addr   (sram_addr),
        .sram_ack    (sram_ack),
        .sram_rdata  (sram_rdata),
        .pc_accept   (pc_accept),
        .fetch_busy  (fetch_busy),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference model: buffered words in a queue plus at most one outstanding fetch.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      m_q[$];
    bit          m_inflight;
    bit          m_discard;
    bit          m_err;
    int          m_wait;
    logic [31:0] m_pc;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        fl;
        logic        st;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_acc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic req, input logic [31:0] pc, input logic fl,
                                    input logic st, input logic ack, input logic [31:0] rd,
                                    input logic e_req, input logic [31:0] e_addr, input logic e_acc,
                                    input logic e_valid, input logic [31:0] e_pc,
                                    input logic [31:0] e_instr);
        vec_t v;
        v = '{req, pc, fl, st, ack, rd, e_req, e_addr, e_acc, e_valid, e_pc, e_instr};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inflight = 0;
        m_discard  = 0;
        m_err      = 0;
        m_wait     = 0;
        m_pc       = '0;
    endtask

    task automatic drive(input logic req, input logic [31:0] pc, input logic fl, input logic st,
                         input logic ack, input logic [31:0] rd);
        fetch_req  = req;
        fetch_pc   = pc;
        flush      = fl;
        id_stall   = st;
        sram_ack   = ack;
        sram_rdata = rd;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step(input int row);
        bit     acc;
        bit     lands;
        entry_t head;
        @(negedge clk);
        lands = m_inflight && sram_ack && !m_discard && !flush;
        acc   = fetch_req && !flush && (!m_inflight || sram_ack) &&
                ((m_q.size() + (lands ? 1 : 0)) < DEPTH);
        head  = (m_q.size() != 0) ? m_q[0] : '0;
        check("pc_accept", pc_accept, acc);
        check("fetch_busy", fetch_busy, fetch_req && !acc);
        check("sram_req", sram_req, m_inflight);
        if (m_inflight) check("sram_addr", sram_addr, m_pc);
        check("instr_valid", instr_valid, m_q.size() != 0);
        check("instr", instr, head.data);
        check("instr_pc", instr_pc, head.pc);
        check("fetch_err", fetch_err, m_err);
        if (row >= 0) begin
            vec_t r;
            r = vecs[row];
            check($sformatf("tbl%0d_sram_req", row), sram_req, r.e_req);
            if (r.e_req) check($sformatf("tbl%0d_sram_addr", row), sram_addr, r.e_addr);
            check($sformatf("tbl%0d_accept", row), pc_accept, r.e_acc);
            check($sformatf("tbl%0d_busy", row), fetch_busy, r.req && !r.e_acc);
            check($sformatf("tbl%0d_valid", row), instr_valid, r.e_valid);
            check($sformatf("tbl%0d_instr_pc", row), instr_pc, r.e_pc);
            check($sformatf("tbl%0d_instr", row), instr, r.e_instr);
        end
        if (m_q.size() != 0 && !id_stall) void'(m_q.pop_front());
        if (flush) m_q.delete();
        if (m_inflight && sram_ack) begin
            if (lands) m_q.push_back({m_pc, sram_rdata});
            m_inflight = 0;
            m_discard  = 0;
        end else if (m_inflight) begin
            if (flush) m_discard = 1;
            m_wait++;
            if (m_wait == MAX_LAT) begin
                m_err      = 1;
                m_inflight = 0;
                m_discard  = 0;
            end
        end
        if (acc) begin
            m_inflight = 1;
            m_pc       = fetch_pc & 32'hFFFF_FFFC;
            m_discard  = 0;
            m_wait     = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sram_req"}, sram_req, 0);
        check({tag, "_sram_addr"}, sram_addr, 0);
        check({tag, "_pc_accept"}, pc_accept, 0);
        check({tag, "_fetch_busy"}, fetch_busy, 0);
        check({tag, "_instr_valid"}, instr_valid, 0);
        check({tag, "_instr"}, instr, 0);
        check({tag, "_instr_pc"}, instr_pc, 0);
        check({tag, "_fetch_err"}, fetch_err, 0);
    endtask

    initial begin
        int cyc;

        // Stream: reissue on the first ack, pre-pop room forces one idle cycle later.
        add_vec(1, 'h0, 0, 0, 0, 0,            0, 'h0, 1, 0, 'h0, 'h0);
        add_vec(1, 'h4, 0, 0, 1, 'h1111_0000,  1, 'h0, 1, 0, 'h0, 'h0);
        add_vec(1, 'h8, 0, 0, 1, 'h2222_0004,  1, 'h4, 0, 1, 'h0, 'h1111_0000);
        add_vec(1, 'hB, 0, 0, 0, 0,            0, 'h0, 1, 1, 'h4, 'h2222_0004);
        add_vec(0, 'h0, 0, 0, 1, 'h3333_0008,  1, 'h8, 0, 0, 'h0, 'h0);
        add_vec(0, 'h0, 0, 0, 0, 0,            0, 'h0, 0, 1, 'h8, 'h3333_0008);
        add_vec(0, 'h0, 0, 0, 0, 0,            0, 'h0, 0, 0, 'h0, 'h0);
        // Back-pressure: two buffered, third held off until the stall releases.
        add_vec(1, 'h0, 0, 1, 0, 0,            0, 'h0, 1, 0, 'h0, 'h0);
        add_vec(1, 'h4, 0, 1, 1, 'hA0,         1, 'h0, 1, 0, 'h0, 'h0);
        add_vec(1, 'h8, 0, 1, 1, 'hA4,         1, 'h4, 0, 1, 'h0, 'hA0);
        add_vec(1, 'h8, 0, 1, 0, 0,            0, 'h0, 0, 1, 'h0, 'hA0);
        add_vec(1, 'h8, 0, 0, 0, 0,            0, 'h0, 0, 1, 'h0, 'hA0);
        add_vec(1, 'h8, 0, 0, 0, 0,            0, 'h0, 1, 1, 'h4, 'hA4);
        add_vec(1, 'hC, 0, 0, 1, 'hA8,         1, 'h8, 1, 0, 'h0, 'h0);
        add_vec(0, 'h0, 0, 0, 1, 'hAC,         1, 'hC, 0, 1, 'h8, 'hA8);
        add_vec(0, 'h0, 0, 0, 0, 0,            0, 'h0, 0, 1, 'hC, 'hAC);
        add_vec(0, 'h0, 0, 0, 0, 0,            0, 'h0, 0, 0, 'h0, 'h0);
        // Flush while waiting: the late response is squashed, next fetch is clean.
        add_vec(1, 'h10, 0, 0, 0, 0,           0, 'h0,  1, 0, 'h0, 'h0);
        add_vec(0, 'h0,  1, 0, 0, 0,           1, 'h10, 0, 0, 'h0, 'h0);
        add_vec(0, 'h0,  0, 0, 0, 0,           1, 'h10, 0, 0, 'h0, 'h0);
        add_vec(0, 'h0,  0, 0, 1, 'hDEAD_BEEF, 1, 'h10, 0, 0, 'h0, 'h0);
        add_vec(1, 'h40, 0, 0, 0, 0,           0, 'h0,  1, 0, 'h0, 'h0);
        add_vec(0, 'h0,  0, 0, 1, 'h4040_4040, 1, 'h40, 0, 0, 'h0, 'h0);
        add_vec(0, 'h0,  0, 0, 0, 0,           0, 'h0,  0, 1, 'h40, 'h4040_4040);
        add_vec(0, 'h0,  0, 0, 0, 0,           0, 'h0,  0, 0, 'h0, 'h0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].pc, vecs[i].fl, vecs[i].st, vecs[i].ack, vecs[i].rd);
            step(i);
        end

        // Flush with a full FIFO.
        drive(1, 32'h100, 0, 1, 0, 0);           step(-1);
        drive(1, 32'h104, 0, 1, 1, 32'h5000_0100); step(-1);
        drive(1, 32'h108, 0, 1, 1, 32'h5000_0104); step(-1);
        drive(1, 32'h108, 1, 1, 0, 0);           step(-1);
        check("flush_full_valid", instr_valid, 0);
        check("flush_full_sram_req", sram_req, 0);

        // Flush coincident with an ack while the buffer plus in-flight slot are full.
        drive(1, 32'h200, 0, 1, 0, 0);           step(-1);
        drive(1, 32'h204, 0, 1, 1, 32'h6000_0200); step(-1);
        drive(1, 32'h208, 1, 1, 1, 32'h6000_0204); step(-1);
        check("flush_ack_valid", instr_valid, 0);
        check("flush_ack_sram_req", sram_req, 0);
        drive(1, 32'h208, 0, 0, 0, 0);           step(-1);
        drive(0, 0, 0, 0, 1, 32'h6000_0208);     step(-1);
        drive(0, 0, 0, 0, 0, 0);                 step(-1);

        // Reset in the middle of a WAIT; a late ack afterwards must be ignored.
        drive(1, 32'h300, 0, 0, 0, 0);           step(-1);
        check("mid_wait_sram_req", sram_req, 1);
        drive(1, 32'h500, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 1, 32'hBAD0_BAD0);     step(-1);
        drive(0, 0, 0, 0, 0, 0);                 step(-1);
        check("late_ack_valid", instr_valid, 0);
        check("late_ack_sram_req", sram_req, 0);

        // Random traffic; the responder always answers well inside the timeout.
        for (int i = 0; i < 3000; i++) begin
            fetch_req  = ($urandom_range(0, 2) != 0);
            fetch_pc   = $urandom();
            flush      = ($urandom_range(0, 11) == 0);
            id_stall   = ($urandom_range(0, 2) == 0);
            sram_rdata = $urandom();
            sram_ack   = m_inflight && ((m_wait >= 8) || ($urandom_range(0, 2) == 0));
            step(-1);
        end

        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, m_inflight, $urandom());
            step(-1);
        end
        check("drain_valid", instr_valid, 0);

        // Timeout: no ack ever returns.
        drive(1, 32'h600, 0, 0, 0, 0);           step(-1);
        drive(0, 0, 0, 0, 0, 0);
        cyc = 0;
        while (!fetch_err && cyc < 20) begin
            step(-1);
            cyc++;
        end
        check("timeout_cycles", cyc, MAX_LAT);
        check("timeout_sram_req", sram_req, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom());
            step(-1);
            check("err_sticky", fetch_err, 1);
        end
        rst_n = 1'b0;
        #1 check("err_cleared_by_reset", fetch_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
